// File: rtl/wave_capture_ctrl.sv
// Capture sequencer for the double-buffered wave display sample RAM.
// Triggers on a rising zero crossing (or timeout) and fills the idle half.
module wave_capture_ctrl #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_ready,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                frame_done,
    output logic                write_en,
    output logic [ADDR_W:0]     write_address,
    output logic [7:0]          write_sample,
    output logic                read_index,
    output logic                capturing,
    output logic                forced
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        ARMED,
        ACTIVE,
        WAIT_FRAME
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  tcount;
    logic              prev_neg;

    logic              neg;
    logic              trig;
    logic [7:0]        conv;
    logic              unused_low;

    assign neg        = sample_in[SAMPLE_W-1];
    assign trig       = sample_ready & prev_neg & ~neg;
    assign conv       = {~neg, sample_in[SAMPLE_W-2 -: 7]};
    assign unused_low = ^sample_in[SAMPLE_W-9:0];

    // The write half is always the one the display is not reading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARMED;
            idx           <= '0;
            tcount        <= '0;
            prev_neg      <= 1'b0;
            write_en      <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
            read_index    <= 1'b0;
            capturing     <= 1'b0;
            forced        <= 1'b0;
        end else begin
            write_en <= 1'b0;
            if (sample_ready) begin
                prev_neg <= neg;
            end
            unique case (state)
                ARMED: begin
                    if (sample_ready) begin
                        if (trig || tcount == CNT_LAST) begin
                            write_en      <= 1'b1;
                            write_address <= {~read_index, {ADDR_W{1'b0}}};
                            write_sample  <= conv;
                            idx           <= ADDR_W'(1);
                            forced        <= ~trig;
                            tcount        <= '0;
                            capturing     <= 1'b1;
                            state         <= ACTIVE;
                        end else begin
                            tcount <= tcount + 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (sample_ready) begin
                        write_en      <= 1'b1;
                        write_address <= {~read_index, idx};
                        write_sample  <= conv;
                        idx           <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            capturing <= 1'b0;
                            state     <= WAIT_FRAME;
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (frame_done) begin
                        read_index <= ~read_index;
                        state      <= ARMED;
                    end
                end
                default: begin
                    state <= ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed self-checking bench for wave_capture_ctrl.
// Hand-computed expectations checked with immediate assertions.
module tb_wave_capture_ctrl;

    logic        clk;
    logic        reset;
    logic        sample_ready;
    logic [15:0] sample_in;
    logic        frame_done;
    logic        write_en;
    logic [8:0]  write_address;
    logic [7:0]  write_sample;
    logic        read_index;
    logic        capturing;
    logic        forced;

    int checks = 0;
    int errors = 0;

    wave_capture_ctrl #(
        .SAMPLE_W(16),
        .ADDR_W(8),
        .TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_ready(sample_ready),
        .sample_in(sample_in),
        .frame_done(frame_done),
        .write_en(write_en),
        .write_address(write_address),
        .write_sample(write_sample),
        .read_index(read_index),
        .capturing(capturing),
        .forced(forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the clock edge.
    task automatic cyc(input logic sr, input logic [15:0] s, input logic fd);
        sample_ready = sr;
        sample_in    = s;
        frame_done   = fd;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        frame_done   = 1'b0;
    endtask

    initial begin
        int nw;
        int nc;
        logic [7:0] i8;
        reset        = 1'b0;
        sample_ready = 1'b0;
        sample_in    = '0;
        frame_done   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", write_en, 0);
        chk("rst_addr", write_address, 0);
        chk("rst_samp", write_sample, 0);
        chk("rst_ridx", read_index, 0);
        chk("rst_capt", capturing, 0);
        chk("rst_forced", forced, 0);
        reset = 1'b1;
        cyc(0, 16'h0000, 0);

        // Trigger on negative -> non-negative crossing
        cyc(1, 16'hFF00, 0);
        chk("pre_trig_we", write_en, 0);
        cyc(1, 16'h0200, 0);
        chk("trig_we", write_en, 1);
        chk("trig_addr", write_address, 9'h100);
        chk("trig_samp", write_sample, 8'h82);
        chk("trig_forced", forced, 0);
        chk("trig_capt", capturing, 1);
        cyc(0, 16'h0000, 0);
        chk("we_one_cycle", write_en, 0);

        // Rest of buffer, with frame_done pulses that must be ignored
        for (int i = 1; i < 256; i++) begin
            i8 = 8'(i);
            cyc(1, {i8, 8'h00}, 0);
            chk("fill1_we", write_en, 1);
            chk("fill1_addr", write_address, 9'h100 + 9'(i));
            chk("fill1_samp", write_sample, i8 ^ 8'h80);
            if (i % 64 == 0) begin
                cyc(0, 16'h0000, 1);
                chk("active_fd_ridx", read_index, 0);
            end
        end
        chk("fill1_capt_drop", capturing, 0);
        cyc(1, 16'h0100, 0);
        chk("wait_no_we", write_en, 0);
        chk("wait_ridx", read_index, 0);
        cyc(0, 16'h0000, 1);
        chk("flip1_ridx", read_index, 1);
        chk("flip1_capt", capturing, 0);

        // Second capture into lower half, samples every cycle
        cyc(1, 16'h8000, 0);
        chk("arm2_we", write_en, 0);
        cyc(1, 16'h0000, 0);
        chk("cap2_addr0", write_address, 9'h000);
        chk("cap2_samp0", write_sample, 8'h80);
        chk("cap2_we0", write_en, 1);
        for (int i = 1; i < 256; i++) begin
            cyc(1, 16'h0000, (i == 255) ? 1'b1 : 1'b0);
            chk("fill2_addr", write_address, 9'(i));
            chk("fill2_we", write_en, 1);
        end
        chk("coinc_fd_ridx", read_index, 1);
        cyc(1, 16'h7F00, 0);
        chk("wait2_we_a", write_en, 0);
        chk("wait2_ridx", read_index, 1);
        cyc(1, 16'hFF00, 0);
        chk("wait2_we_b", write_en, 0);
        cyc(1, 16'h0300, 1);
        chk("simul_flip_ridx", read_index, 0);
        chk("simul_no_we", write_en, 0);
        chk("simul_capt", capturing, 0);
        cyc(1, 16'h0300, 0);
        chk("simul_no_trig", write_en, 0);

        // Trigger again then reset mid-capture
        cyc(1, 16'hFF00, 0);
        cyc(1, 16'h0000, 0);
        chk("cap3_addr", write_address, 9'h100);
        cyc(1, 16'h0000, 0);
        chk("cap3_addr1", write_address, 9'h101);
        reset = 1'b0;
        #1;
        chk("async_rst_we", write_en, 0);
        chk("async_rst_addr", write_address, 0);
        chk("async_rst_capt", capturing, 0);
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        chk("rst_hold_we", write_en, 0);
        chk("rst_hold_samp", write_sample, 0);
        chk("rst_hold_ridx", read_index, 0);
        reset = 1'b1;

        // Timeout: 1023 positive samples give nothing, 1024th is forced
        nw = 0;
        nc = 0;
        for (int i = 0; i < 1023; i++) begin
            cyc(1, 16'h1000, 0);
            if (write_en) nw++;
            if (capturing) nc++;
        end
        chk("timeout_no_writes", nw, 0);
        chk("timeout_no_capt", nc, 0);
        cyc(1, 16'h1234, 0);
        chk("timeout_we", write_en, 1);
        chk("timeout_addr", write_address, 9'h100);
        chk("timeout_samp", write_sample, 8'h92);
        chk("timeout_forced", forced, 1);
        chk("timeout_capt", capturing, 1);
        for (int i = 1; i < 256; i++) begin
            cyc(1, 16'h0000, 0);
        end
        chk("timeout_last_addr", write_address, 9'h1FF);
        chk("forced_holds", forced, 1);
        cyc(0, 16'h0000, 1);
        chk("flip3_ridx", read_index, 1);
        cyc(1, 16'hFF00, 0);
        cyc(1, 16'h0100, 0);
        chk("cap4_addr", write_address, 9'h000);
        chk("cap4_samp", write_sample, 8'h81);
        chk("cap4_forced_clr", forced, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
